id_alu_issue: RTL and testbench



---
 rtl/id_alu_issue_pkg.sv | 38 +++
 rtl/id_alu_issue_if.sv | 41 ++++
 rtl/id_alu_issue_alu_decode.sv | 98 +++++++++
 rtl/id_alu_issue.sv | 90 +++++++++
 tb/tb_id_alu_issue.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_alu_issue_pkg.sv
// Shared RV32I ALU-issue definitions: opcodes, ALU op encodings (shared with
// the EX-stage ALU) and immediate helpers.
package id_alu_issue_pkg;

  localparam int XLEN    = 32;
  localparam int IMM_I_W = 12;
  localparam int IMM_U_W = 20;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  function automatic logic [XLEN-1:0] imm_i(input logic [XLEN-1:0] instr);
    return {{(XLEN-IMM_I_W){instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [XLEN-1:0] instr);
    return {instr[31:12], {(XLEN-IMM_U_W){1'b0}}};
  endfunction

endpackage

// File: rtl/id_alu_issue_if.sv
// Decode-to-EX ALU control bundle: fetch input, regfile read port and the
// registered ID/EX outputs. master = decode stage, slave = its environment.
interface id_alu_issue_if;
  import id_alu_issue_pkg::*;

  // Handshake: an instruction moves from IF into ID/EX on a rising clk edge
  // when if_valid && id_ready && !ex_flush; with ex_stall high and ex_valid
  // high the ID/EX register holds and id_ready is low.
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_rdata;
  logic [XLEN-1:0] rs2_rdata;
  logic            ex_stall;
  logic            ex_flush;
  logic            ex_valid;
  logic            ex_alu_class;
  logic [3:0]      ex_alu_op;
  logic [XLEN-1:0] ex_alu_oprand_0;
  logic [XLEN-1:0] ex_alu_oprand_1;
  logic [4:0]      ex_rd;
  logic            ex_rd_wen;
  logic            ex_illegal;
  logic [XLEN-1:0] ex_pc;

  modport master (
    input  if_valid, if_instr, if_pc, rs1_rdata, rs2_rdata, ex_stall, ex_flush,
    output id_ready, rs1_addr, rs2_addr, ex_valid, ex_alu_class, ex_alu_op,
           ex_alu_oprand_0, ex_alu_oprand_1, ex_rd, ex_rd_wen, ex_illegal, ex_pc
  );

  modport slave (
    output if_valid, if_instr, if_pc, rs1_rdata, rs2_rdata, ex_stall, ex_flush,
    input  id_ready, rs1_addr, rs2_addr, ex_valid, ex_alu_class, ex_alu_op,
           ex_alu_oprand_0, ex_alu_oprand_1, ex_rd, ex_rd_wen, ex_illegal, ex_pc
  );

endinterface

// File: rtl/id_alu_issue_alu_decode.sv
// Combinational decode of one RV32I word into ALU op, operands and
// writeback control for the OP / OP-IMM / LUI / AUIPC classes.
module id_alu_issue_alu_decode
  import id_alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_rs1_rdata,
  input  logic [DATA_WIDTH-1:0] i_rs2_rdata,
  output logic                  o_alu_class,
  output alu_op_e               o_alu_op,
  output logic [DATA_WIDTH-1:0] o_oprand_0,
  output logic [DATA_WIDTH-1:0] o_oprand_1,
  output logic                  o_rd_wen,
  output logic                  o_illegal
);

  logic [6:0] w_opcode;
  logic [6:0] w_funct7;
  logic [2:0] w_funct3;
  logic [4:0] w_rd;
  logic       w_is_op;
  logic       w_is_op_imm;
  logic       w_is_alt;
  logic       w_illegal;
  alu_op_e    w_f3_op;

  assign w_opcode    = i_instr[6:0];
  assign w_rd        = i_instr[11:7];
  assign w_funct3    = i_instr[14:12];
  assign w_funct7    = i_instr[31:25];
  assign w_is_op     = (w_opcode == OPC_OP);
  assign w_is_op_imm = (w_opcode == OPC_OP_IMM);
  assign w_is_alt    = (w_funct7 == F7_ALT);

  always_comb begin
    w_f3_op = ALU_ADD;
    case (w_funct3)
      3'b000: if (w_is_op && w_is_alt) w_f3_op = ALU_SUB;
              else                     w_f3_op = ALU_ADD;
      3'b001: w_f3_op = ALU_SLL;
      3'b010: w_f3_op = ALU_SLT;
      3'b011: w_f3_op = ALU_SLTU;
      3'b100: w_f3_op = ALU_XOR;
      3'b101: if (w_is_alt) w_f3_op = ALU_SRA;
              else          w_f3_op = ALU_SRL;
      3'b110: w_f3_op = ALU_OR;
      default: w_f3_op = ALU_AND;
    endcase
  end

  // Only the alternate funct7 on ADD/SUB and SRL/SRA escapes the base encoding.
  always_comb begin
    w_illegal = 1'b0;
    if (w_is_op) begin
      w_illegal = !((w_funct7 == F7_BASE) ||
                    (w_is_alt && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
    end else if (w_is_op_imm) begin
      w_illegal = ((w_funct3 == 3'b001) && (w_funct7 != F7_BASE)) ||
                  ((w_funct3 == 3'b101) && (w_funct7 != F7_BASE) && !w_is_alt);
    end
  end

  always_comb begin
    o_alu_class = 1'b0;
    o_alu_op    = ALU_ADD;
    o_oprand_0  = i_rs1_rdata;
    o_oprand_1  = i_rs2_rdata;
    case (w_opcode)
      OPC_OP: begin
        o_alu_class = 1'b1;
        o_alu_op    = w_f3_op;
      end
      OPC_OP_IMM: begin
        o_alu_class = 1'b1;
        o_alu_op    = w_f3_op;
        o_oprand_1  = imm_i(i_instr);
      end
      OPC_LUI: begin
        o_alu_class = 1'b1;
        o_oprand_0  = '0;
        o_oprand_1  = imm_u(i_instr);
      end
      OPC_AUIPC: begin
        o_alu_class = 1'b1;
        o_oprand_0  = i_pc;
        o_oprand_1  = imm_u(i_instr);
      end
      default: ;
    endcase
    if (w_illegal) o_alu_op = ALU_AND;
    o_illegal = w_illegal;
    o_rd_wen  = o_alu_class && !w_illegal && (w_rd != 5'd0);
  end

endmodule

// File: rtl/id_alu_issue.sv
// ID stage ALU issue: decodes the fetched word and registers it into the
// ID/EX pipeline register with stall/flush control.
module id_alu_issue
  import id_alu_issue_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic          clk,
  input  logic          rst_b,
  id_alu_issue_if.master bus
);

  logic                  w_advance;
  logic                  w_alu_class;
  alu_op_e               w_alu_op;
  logic [DATA_WIDTH-1:0] w_oprand_0;
  logic [DATA_WIDTH-1:0] w_oprand_1;
  logic                  w_rd_wen;
  logic                  w_illegal;

  logic                  r_valid;
  logic                  r_alu_class;
  alu_op_e               r_alu_op;
  logic [DATA_WIDTH-1:0] r_oprand_0;
  logic [DATA_WIDTH-1:0] r_oprand_1;
  logic [4:0]            r_rd;
  logic                  r_rd_wen;
  logic                  r_illegal;
  logic [DATA_WIDTH-1:0] r_pc;

  assign bus.rs1_addr = bus.if_instr[19:15];
  assign bus.rs2_addr = bus.if_instr[24:20];
  assign w_advance    = !bus.ex_stall || !r_valid;
  assign bus.id_ready = w_advance;

  id_alu_issue_alu_decode #(.DATA_WIDTH(DATA_WIDTH)) u_alu_decode (
    .i_instr     (bus.if_instr),
    .i_pc        (bus.if_pc),
    .i_rs1_rdata (bus.rs1_rdata),
    .i_rs2_rdata (bus.rs2_rdata),
    .o_alu_class (w_alu_class),
    .o_alu_op    (w_alu_op),
    .o_oprand_0  (w_oprand_0),
    .o_oprand_1  (w_oprand_1),
    .o_rd_wen    (w_rd_wen),
    .o_illegal   (w_illegal)
  );

  // Flush beats stall: a killed slot never lingers as a stalled valid entry.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)             r_valid <= 1'b0;
    else if (bus.ex_flush)  r_valid <= 1'b0;
    else if (w_advance)     r_valid <= bus.if_valid;
  end

  // Payload follows advance only; its value is meaningless whenever r_valid=0.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_alu_class <= 1'b0;
      r_alu_op    <= ALU_ADD;
      r_oprand_0  <= '0;
      r_oprand_1  <= '0;
      r_rd        <= 5'd0;
      r_rd_wen    <= 1'b0;
      r_illegal   <= 1'b0;
      r_pc        <= RESET_PC;
    end else if (w_advance) begin
      r_alu_class <= w_alu_class;
      r_alu_op    <= w_alu_op;
      r_oprand_0  <= w_oprand_0;
      r_oprand_1  <= w_oprand_1;
      r_rd        <= bus.if_instr[11:7];
      r_rd_wen    <= w_rd_wen;
      r_illegal   <= w_illegal;
      r_pc        <= bus.if_pc;
    end
  end

  assign bus.ex_valid        = r_valid;
  assign bus.ex_alu_class    = r_alu_class;
  assign bus.ex_alu_op       = r_alu_op;
  assign bus.ex_alu_oprand_0 = r_oprand_0;
  assign bus.ex_alu_oprand_1 = r_oprand_1;
  assign bus.ex_rd           = r_rd;
  assign bus.ex_rd_wen       = r_rd_wen;
  assign bus.ex_illegal      = r_illegal;
  assign bus.ex_pc           = r_pc;

endmodule

// File: tb/tb_id_alu_issue.sv
// Bench for id_alu_issue: directed literal cases, then random traffic checked
// every cycle against an instruction-level reference model.
module tb_id_alu_issue;
  import id_alu_issue_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  typedef struct packed {
    logic        cls;
    logic [3:0]  op;
    logic [31:0] op0;
    logic [31:0] op1;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  id_alu_issue_if bus ();

  id_alu_issue #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  // Register file behind the read port.
  logic [31:0] rf [32];
  assign bus.rs1_rdata = rf[bus.rs1_addr];
  assign bus.rs2_rdata = rf[bus.rs2_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int f3_op_tbl [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
    exp_t       e;
    logic [6:0] opc = instr[6:0];
    logic [2:0] f3  = instr[14:12];
    logic [6:0] f7  = instr[31:25];
    logic       legal = 1'b1;
    e.cls = 1'b0; e.op = 4'd0; e.rd = instr[11:7]; e.pc = pc;
    e.op0 = rf[instr[19:15]]; e.op1 = rf[instr[24:20]];
    e.wen = 1'b0; e.ill = 1'b0;
    if (opc == 7'h33 || opc == 7'h13) begin
      e.cls = 1'b1;
      e.op  = 4'(f3_op_tbl[f3]);
      if (f3 == 3'd5 && f7 == 7'h20) e.op = 4'd7;
      if (opc == 7'h33) begin
        if (f3 == 3'd0 && f7 == 7'h20) e.op = 4'd1;
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end else begin
        e.op1 = 32'($signed(instr[31:20]));
        legal = !(f3 == 3'd1 && f7 != 7'h00) &&
                !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
    end else if (opc == 7'h37 || opc == 7'h17) begin
      e.cls = 1'b1;
      e.op0 = (opc == 7'h17) ? pc : 32'd0;
      e.op1 = instr & 32'hFFFF_F000;
    end
    if (e.cls && !legal) begin
      e.ill = 1'b1;
      e.op  = 4'd9;
    end
    e.wen = e.cls && !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  exp_t m;
  logic m_valid = 1'b0;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_valid = 1'b0;
      m = '{cls: 1'b0, op: 4'd0, op0: 32'd0, op1: 32'd0, rd: 5'd0,
            wen: 1'b0, ill: 1'b0, pc: RST_PC};
    end else if (bus.ex_flush) begin
      m_valid = 1'b0;
    end else if (!bus.ex_stall || !m_valid) begin
      m_valid = bus.if_valid;
      m = ref_decode(bus.if_instr, bus.if_pc);
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (rst_b) begin
      chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
      chk("id_ready", 32'(bus.id_ready), 32'(!bus.ex_stall || !m_valid));
      chk("rs1_addr", 32'(bus.rs1_addr), 32'(bus.if_instr[19:15]));
      chk("rs2_addr", 32'(bus.rs2_addr), 32'(bus.if_instr[24:20]));
      if (m_valid) begin
        chk("ex_alu_class", 32'(bus.ex_alu_class), 32'(m.cls));
        chk("ex_alu_op", 32'(bus.ex_alu_op), 32'(m.op));
        chk("ex_alu_oprand_0", bus.ex_alu_oprand_0, m.op0);
        chk("ex_alu_oprand_1", bus.ex_alu_oprand_1, m.op1);
        chk("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
        chk("ex_rd_wen", 32'(bus.ex_rd_wen), 32'(m.wen));
        chk("ex_illegal", 32'(bus.ex_illegal), 32'(m.ill));
        chk("ex_pc", bus.ex_pc, m.pc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic st, input logic fl);
    @(negedge clk);
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.if_pc    = pc;
    bus.ex_stall = st;
    bus.ex_flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] opc;
    logic [6:0] f7;
    int sel = $urandom_range(0, 9);
    int fs  = $urandom_range(0, 3);
    logic [31:0] w = $urandom;
    if (sel <= 3)      opc = 7'h33;
    else if (sel <= 6) opc = 7'h13;
    else if (sel == 7) opc = 7'h37;
    else if (sel == 8) opc = 7'h17;
    else               opc = {w[6:2], 2'b11};
    f7 = (fs <= 1) ? 7'h00 : (fs == 2) ? 7'h20 : w[31:25];
    return {f7, w[24:7], opc};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    bus.if_valid = 1'b0; bus.if_instr = 32'h0; bus.if_pc = 32'h0;
    bus.ex_stall = 1'b0; bus.ex_flush = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    chk("reset ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("reset ex_alu_op", 32'(bus.ex_alu_op), 32'd0);
    chk("reset ex_pc", bus.ex_pc, RST_PC);
    chk("reset ex_rd_wen", 32'(bus.ex_rd_wen), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // sub x0,x1,x2
    drive(1'b1, 32'h4020_8033, 32'h200, 1'b0, 1'b0); tick();
    chk("sub op", 32'(bus.ex_alu_op), 32'd1);
    chk("sub op0", bus.ex_alu_oprand_0, 32'd5);
    chk("sub op1", bus.ex_alu_oprand_1, 32'd7);
    chk("sub rd", 32'(bus.ex_rd), 32'd0);
    chk("sub wen", 32'(bus.ex_rd_wen), 32'd0);
    // addi x3,x0,-1
    drive(1'b1, 32'hFFF0_0193, 32'h204, 1'b0, 1'b0); tick();
    chk("addi op", 32'(bus.ex_alu_op), 32'd0);
    chk("addi op1", bus.ex_alu_oprand_1, 32'hFFFF_FFFF);
    chk("addi rd", 32'(bus.ex_rd), 32'd3);
    chk("addi wen", 32'(bus.ex_rd_wen), 32'd1);
    // srai x5,x6,4
    drive(1'b1, 32'h4043_5293, 32'h208, 1'b0, 1'b0); tick();
    chk("srai op", 32'(bus.ex_alu_op), 32'd7);
    chk("srai shamt", 32'(bus.ex_alu_oprand_1[4:0]), 32'd4);
    chk("srai ill", 32'(bus.ex_illegal), 32'd0);
    // auipc x1,0x12345 at pc 0x100
    drive(1'b1, 32'h1234_5097, 32'h100, 1'b0, 1'b0); tick();
    chk("auipc op0", bus.ex_alu_oprand_0, 32'h100);
    chk("auipc op1", bus.ex_alu_oprand_1, 32'h1234_5000);
    chk("auipc wen", 32'(bus.ex_rd_wen), 32'd1);
    // slli x1,x1,3 with funct7=0100000
    drive(1'b1, 32'h4030_9093, 32'h10C, 1'b0, 1'b0); tick();
    chk("slli-alt ill", 32'(bus.ex_illegal), 32'd1);
    chk("slli-alt wen", 32'(bus.ex_rd_wen), 32'd0);
    chk("slli-alt op", 32'(bus.ex_alu_op), 32'd9);
    // stall 3 cycles with add x4,x1,x2 waiting
    drive(1'b1, 32'h0020_8233, 32'h110, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall id_ready", 32'(bus.id_ready), 32'd0);
      chk("stall hold op", 32'(bus.ex_alu_op), 32'd9);
      chk("stall hold pc", bus.ex_pc, 32'h10C);
    end
    drive(1'b1, 32'h0020_8233, 32'h110, 1'b0, 1'b0); tick();
    chk("release op", 32'(bus.ex_alu_op), 32'd0);
    chk("release rd", 32'(bus.ex_rd), 32'd4);
    chk("release op1", bus.ex_alu_oprand_1, 32'd7);
    chk("release pc", bus.ex_pc, 32'h110);
    // stall + flush together
    drive(1'b1, 32'hFFF0_0193, 32'h114, 1'b1, 1'b1); tick();
    chk("stall+flush valid", 32'(bus.ex_valid), 32'd0);
    drive(1'b1, 32'hFFF0_0193, 32'h114, 1'b0, 1'b0); tick();
    chk("reload valid", 32'(bus.ex_valid), 32'd1);
    drive(1'b0, 32'hFFF0_0193, 32'h118, 1'b0, 1'b0); tick();
    chk("bubble valid", 32'(bus.ex_valid), 32'd0);
    // asynchronous reset in the middle of a stall
    drive(1'b1, 32'h0020_8233, 32'h300, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h4020_8033, 32'h304, 1'b1, 1'b0); tick();
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("async rst valid", 32'(bus.ex_valid), 32'd0);
    chk("async rst op", 32'(bus.ex_alu_op), 32'd0);
    chk("async rst pc", bus.ex_pc, RST_PC);
    @(negedge clk);
    rst_b = 1'b1;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(1, 31)] = $urandom;
      bus.if_valid = ($urandom_range(0, 9) < 8);
      bus.if_instr = gen_instr();
      bus.if_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      bus.ex_stall = ($urandom_range(0, 9) < 3);
      bus.ex_flush = ($urandom_range(0, 11) == 0);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
